uart_io_arbiter: RTL and testbench
==================================

UART_IO_ARBITER -- requirements
Module: uart_io_arbiter

Interface
REQ-001 SHALL have parameter: clk_freq, 50000000, system clock in Hz (documentation only, no effect on logic).
REQ-002 SHALL have parameter: TIMEOUT_CYC, 1024, GRANT-state watchdog limit in cycles (valid range 2..65535).
REQ-003 SHALL have port: clk  in  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: req0/req1  in  1  transfer request from requester 0 (CPU MMIO) / 1 (IO port).
REQ-006 SHALL have ports: wr0/wr1  in  1  transfer direction, 1 = write to TX, 0 = read from RX.
REQ-007 SHALL have ports: wdata0/wdata1  in  8  TX byte.
REQ-008 SHALL have ports: ack0/ack1  out  1  one-cycle completion pulse.
REQ-009 SHALL have ports: rdata0/rdata1  out  8  last RX byte delivered to that requester.
REQ-010 SHALL have port: gnt  out  2  one-hot grant, bit n = requester n owns the UART.
REQ-011 SHALL have ports: uart_wr  out  1  TX load strobe; uart_wdata  out  8  TX byte; uart_busy  in  1  transmitter busy.
REQ-012 SHALL have ports: uart_rd  out  1  RX pop strobe; uart_rx_avail  in  1  RX byte present; uart_rdata  in  8  RX byte.
REQ-013 SHALL have port: err  out  1  one-cycle timeout pulse, coincident with ack.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, DONE.
REQ-015 IDLE: no request -> stay; any request -> GRANT next cycle, gnt set, wr/wdata of winner latched.
REQ-016 Arbitration SHALL be round-robin: on simultaneous requests, the requester not served last wins; a sole requester always wins.
REQ-017 GRANT, write: uart_busy=0 -> uart_wr=1 for exactly one cycle with uart_wdata=latched byte, go DONE; uart_busy=1 -> stay.
REQ-018 GRANT, read: uart_rx_avail=1 -> uart_rd=1 for exactly one cycle, capture uart_rdata that cycle into winner's rdata, go DONE; else stay.
REQ-019 DONE: ackN=1 for winner for one cycle, gnt cleared, round-robin pointer updated to winner, go IDLE.
REQ-020 Minimum latency: req sampled in IDLE at edge N -> strobe during cycle N+1 -> ack during cycle N+2.
REQ-021 Requester changes to wr/wdata after grant SHALL be ignored until next IDLE.
REQ-022 req still high in IDLE after ack SHALL be treated as a new request, subject to round-robin.
REQ-023 Requester dropping req during GRANT SHALL NOT abort the transfer.
REQ-024 uart_wr and uart_rd SHALL never be high in the same cycle; at most one strobe per grant.
REQ-025 rdataN SHALL hold its value until the next completed read for requester N; writes leave it unchanged.
REQ-026 gnt SHALL be zero in IDLE and DONE and one-hot in GRANT.

Reset
REQ-027 rst low SHALL immediately force: FSM IDLE, gnt=0, ack0=ack1=0, uart_wr=uart_rd=0, uart_wdata=0, rdata0=rdata1=0, err=0, timeout counter=0, round-robin pointer=1 (requester 0 wins first).
REQ-028 Reset during GRANT SHALL abandon the transfer with no strobe and no ack.
REQ-029 After rst rises, first arbitration SHALL occur on the first clock edge with req sampled high.

Configuration
REQ-030 Macro UART_ARB_TIMEOUT_EN defined: 16-bit counter clears on IDLE->GRANT and increments each GRANT cycle with no strobe; on reaching TIMEOUT_CYC-1 -> DONE with err=1, ack=1, no strobe, rdata of winner set to 8'hFF if read.
REQ-031 Macro undefined: no counter, GRANT waits indefinitely, err tied 0.

Verification
REQ-032 req0=1 wr0=1 wdata0=8'h41, uart_busy=0 -> gnt=01 next cycle, uart_wr pulse with 8'h41, ack0 one cycle later.
REQ-033 req0 and req1 both held high for 4 reads, uart_rx_avail=1, uart_rdata=8'h55 -> grants alternate 01,10,01,10; rdata0=rdata1=8'h55.
REQ-034 req1 write with uart_busy=1 for 10 cycles then 0 -> gnt=10 held 10 cycles, single uart_wr, then ack1.
REQ-035 Read with uart_rx_avail=0, TIMEOUT_CYC=8, macro defined -> ack and err same cycle 8 cycles after grant, rdata=8'hFF, no uart_rd; macro undefined -> no ack.
REQ-036 rst low mid-GRANT -> all outputs 0 same cycle; after release req0 and req1 together -> requester 0 granted first.

Source files
------------

// File: rtl/uart_io_arbiter.sv
// Two-requester round-robin arbiter sharing one UART TX/RX byte interface.
// Optional GRANT watchdog is built when UART_ARB_TIMEOUT_EN is defined.
module uart_io_arbiter #(
    parameter int clk_freq    = 50000000,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       wr0,
    input  logic       wr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic [1:0] gnt,
    output logic       uart_wr,
    output logic [7:0] uart_wdata,
    input  logic       uart_busy,
    output logic       uart_rd,
    input  logic       uart_rx_avail,
    input  logic [7:0] uart_rdata,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       wr_q, wr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata0_q, rdata0_d;
    logic [7:0] rdata1_q, rdata1_d;
    logic       wr_stb, rd_stb, win;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        to_q, to_d;
`endif

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535 || clk_freq < 1) begin : g_param_check
        $error("uart_io_arbiter: TIMEOUT_CYC must be 2..65535 and clk_freq positive");
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        wr_stb   = 1'b0;
        rd_stb   = 1'b0;
        // last_q holds the requester served most recently, so a tie goes to the other one
        win      = (req0 && req1) ? ~last_q : req1;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        to_d     = to_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = GRANT;
                    owner_d = win;
                    wr_d    = win ? wr1 : wr0;
                    wdata_d = win ? wdata1 : wdata0;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d   = 16'd0;
                    to_d    = 1'b0;
`endif
                end
            end
            GRANT: begin
                if (wr_q) wr_stb = !uart_busy;
                else      rd_stb = uart_rx_avail;
                if (rd_stb) begin
                    if (owner_q) rdata1_d = uart_rdata;
                    else         rdata0_d = uart_rdata;
                end
                if (wr_stb || rd_stb) begin
                    state_d = DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    to_d    = 1'b1;
                    if (!wr_q) begin
                        if (owner_q) rdata1_d = 8'hFF;
                        else         rdata0_d = 8'hFF;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            wr_q     <= 1'b0;
            wdata_q  <= 8'h00;
            rdata0_q <= 8'h00;
            rdata1_q <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q    <= 16'd0;
            to_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            to_q     <= to_d;
`endif
        end
    end

    // Strobes, grant and ack decode from the state register so reset clears them at once
    assign gnt        = (state_q == GRANT) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign ack0       = (state_q == DONE) && !owner_q;
    assign ack1       = (state_q == DONE) && owner_q;
    assign uart_wr    = wr_stb;
    assign uart_rd    = rd_stb;
    assign uart_wdata = wdata_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign err        = (state_q == DONE) && to_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_io_arbiter.sv
// Self-checking bench for uart_io_arbiter: transaction-level reference model
// (round-robin winner, expected strobe/ack timing, per-requester rdata).
module tb_uart_io_arbiter;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
    logic       ack0, ack1, uart_wr, uart_rd, err;
    logic [7:0] rdata0, rdata1, uart_wdata;
    logic [1:0] gnt;
    logic       uart_busy = 1'b1, uart_rx_avail = 1'b0;
    logic [7:0] uart_rdata = 8'h00;

    logic [6:0] obs;
    int         n_checks = 0;
    int         n_fail = 0;
    logic       last_m;
    logic [7:0] rd_m [2];

    always #5 clk = ~clk;

    uart_io_arbiter #(.clk_freq(50000000), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .gnt(gnt), .uart_wr(uart_wr), .uart_wdata(uart_wdata), .uart_busy(uart_busy),
        .uart_rd(uart_rd), .uart_rx_avail(uart_rx_avail), .uart_rdata(uart_rdata),
        .err(err)
    );

    assign obs = {gnt, uart_wr, uart_rd, ack1, ack0, err};

    function automatic logic [1:0] oh(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    task automatic garble();
        req0   = 1'($urandom);
        req1   = 1'($urandom);
        wr0    = 1'($urandom);
        wr1    = 1'($urandom);
        wdata0 = 8'($urandom);
        wdata1 = 8'($urandom);
    endtask

    // One full transaction from IDLE: k blocked GRANT cycles, then the strobe, then DONE.
    task automatic do_txn(input string tag, input logic r0, input logic r1,
                          input logic w0, input logic w1, input logic [7:0] d0,
                          input logic [7:0] d1, input int k, input logic [7:0] rxb);
        logic       win, ew;
        logic [7:0] ed;
        logic [6:0] exp;
        win = (r0 && r1) ? ~last_m : r1;
        ew  = win ? w1 : w0;
        ed  = win ? d1 : d0;
        req0 = r0; req1 = r1; wr0 = w0; wr1 = w1; wdata0 = d0; wdata1 = d1;
        uart_busy = 1'b1; uart_rx_avail = 1'b0;
        @(negedge clk); n_checks++;
        if (obs !== 7'b0) begin n_fail++; $display("FAIL %s idle: ctl=%b want=%b", tag, obs, 7'b0); end
        @(posedge clk); #1;
        for (int i = 0; i < k; i++) begin
            garble();
            uart_busy = 1'b1; uart_rx_avail = 1'b0;
            exp = {oh(win), 5'b0};
            @(negedge clk); n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL %s wait%0d: ctl=%b want=%b", tag, i, obs, exp); end
            @(posedge clk); #1;
        end
        garble();
        uart_busy = 1'b0; uart_rx_avail = 1'b1; uart_rdata = rxb;
        exp = {oh(win), ew, ~ew, 3'b0};
        @(negedge clk); n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL %s strobe: ctl=%b want=%b", tag, obs, exp); end
        if (ew) begin
            n_checks++;
            if (uart_wdata !== ed) begin n_fail++; $display("FAIL %s wdata: got %h want %h", tag, uart_wdata, ed); end
        end
        @(posedge clk); #1;
        if (!ew) rd_m[win] = rxb;
        req0 = 1'b0; req1 = 1'b0; uart_busy = 1'b1; uart_rx_avail = 1'b0;
        exp = {4'b0, win, ~win, 1'b0};
        @(negedge clk); n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL %s done: ctl=%b want=%b", tag, obs, exp); end
        n_checks++;
        if ({rdata1, rdata0} !== {rd_m[1], rd_m[0]}) begin
            n_fail++; $display("FAIL %s rdata: got %h/%h want %h/%h", tag, rdata1, rdata0, rd_m[1], rd_m[0]);
        end
        last_m = win;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1; wr0 = 1'b1; wdata0 = 8'h9C;
        uart_busy = 1'b0; uart_rx_avail = 1'b1; uart_rdata = 8'h33;
        repeat (3) @(posedge clk);
        @(negedge clk); n_checks++;
        if (obs !== 7'b0) begin n_fail++; $display("FAIL reset_ctl: ctl=%b want=%b", obs, 7'b0); end
        n_checks++;
        if ({uart_wdata, rdata1, rdata0} !== 24'h0) begin
            n_fail++; $display("FAIL reset_data: got %h want 000000", {uart_wdata, rdata1, rdata0});
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0; uart_busy = 1'b1; uart_rx_avail = 1'b0;
        rst = 1'b1;
        last_m = 1'b1; rd_m[0] = 8'h00; rd_m[1] = 8'h00;
    endtask

    task automatic test_back_to_back();
        logic       w;
        logic [6:0] exp;
        req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
        uart_busy = 1'b1; uart_rx_avail = 1'b1; uart_rdata = 8'h55;
        for (int t = 0; t < 4; t++) begin
            w = ~last_m;
            @(negedge clk); n_checks++;
            if (obs !== 7'b0) begin n_fail++; $display("FAIL b2b idle%0d: ctl=%b want=%b", t, obs, 7'b0); end
            @(posedge clk); #1;
            exp = {oh(w), 2'b01, 3'b0};
            @(negedge clk); n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL b2b grant%0d: ctl=%b want=%b", t, obs, exp); end
            @(posedge clk); #1;
            rd_m[w] = 8'h55;
            if (t == 3) begin req0 = 1'b0; req1 = 1'b0; end
            exp = {4'b0, w, ~w, 1'b0};
            @(negedge clk); n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL b2b ack%0d: ctl=%b want=%b", t, obs, exp); end
            last_m = w;
            @(posedge clk); #1;
        end
        uart_rx_avail = 1'b0;
        n_checks++;
        if (rdata0 !== 8'h55 || rdata1 !== 8'h55) begin
            n_fail++; $display("FAIL b2b rdata: got %h/%h want 55/55", rdata1, rdata0);
        end
    endtask

    task automatic test_write_basic();
        do_txn("wr41", 1'b1, 1'b0, 1'b1, 1'b0, 8'h41, 8'h00, 0, 8'h00);
    endtask

    task automatic test_busy_hold();
        do_txn("busy10", 1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 8'hC3, 10, 8'h00);
    endtask

    task automatic test_random();
        logic [1:0] pat;
        for (int n = 0; n < 30; n++) begin
            pat = 2'($urandom_range(1, 3));
            do_txn("rand", pat[0], pat[1], 1'($urandom), 1'($urandom), 8'($urandom),
                   8'($urandom), int'($urandom_range(0, 5)), 8'($urandom));
        end
    endtask

    task automatic test_timeout();
        logic       w;
        logic [6:0] exp;
`ifdef UART_ARB_TIMEOUT_EN
        for (int c = 0; c < 2; c++) begin
            w = (c == 1);
            req0 = !w; req1 = w; wr0 = 1'b0; wr1 = 1'b1; wdata1 = 8'h77;
            uart_busy = 1'b1; uart_rx_avail = 1'b0;
            @(negedge clk); n_checks++;
            if (obs !== 7'b0) begin n_fail++; $display("FAIL to%0d idle: ctl=%b want=%b", c, obs, 7'b0); end
            @(posedge clk); #1;
            req0 = 1'b0; req1 = 1'b0;
            exp = {oh(w), 5'b0};
            for (int g = 0; g < TO; g++) begin
                @(negedge clk); n_checks++;
                if (obs !== exp) begin n_fail++; $display("FAIL to%0d wait%0d: ctl=%b want=%b", c, g, obs, exp); end
                @(posedge clk); #1;
            end
            if (!w) rd_m[0] = 8'hFF;
            exp = {4'b0, w, ~w, 1'b1};
            @(negedge clk); n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL to%0d ack_err: ctl=%b want=%b", c, obs, exp); end
            n_checks++;
            if ({rdata1, rdata0} !== {rd_m[1], rd_m[0]}) begin
                n_fail++; $display("FAIL to%0d rdata: got %h/%h want %h/%h", c, rdata1, rdata0, rd_m[1], rd_m[0]);
            end
            last_m = w;
            @(posedge clk); #1;
        end
`else
        w = 1'b0;
        req0 = 1'b1; req1 = 1'b0; wr0 = 1'b0; uart_busy = 1'b1; uart_rx_avail = 1'b0;
        @(posedge clk); #1;
        req0 = 1'b0;
        exp = {2'b01, 5'b0};
        for (int g = 0; g < 40; g++) begin
            @(negedge clk); n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL noto wait%0d: ctl=%b want=%b", g, obs, exp); end
            @(posedge clk); #1;
        end
        uart_rx_avail = 1'b1; uart_rdata = 8'h3C;
        exp = {2'b01, 2'b01, 3'b0};
        @(negedge clk); n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL noto strobe: ctl=%b want=%b", obs, exp); end
        @(posedge clk); #1;
        uart_rx_avail = 1'b0; rd_m[0] = 8'h3C;
        exp = {4'b0, w, ~w, 1'b0};
        @(negedge clk); n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL noto ack: ctl=%b want=%b", obs, exp); end
        n_checks++;
        if (rdata0 !== rd_m[0]) begin n_fail++; $display("FAIL noto rdata: got %h want %h", rdata0, rd_m[0]); end
        last_m = w;
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_reset_mid_grant();
        req0 = 1'b0; req1 = 1'b1; wr1 = 1'b1; wdata1 = 8'hA5;
        uart_busy = 1'b1; uart_rx_avail = 1'b0;
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk); n_checks++;
        if (obs !== 7'b1000000) begin n_fail++; $display("FAIL mid grant: ctl=%b want=%b", obs, 7'b1000000); end
        @(posedge clk); #1;
        uart_busy = 1'b0; #1;
        n_checks++;
        if (obs !== 7'b1010000 || uart_wdata !== 8'hA5) begin
            n_fail++; $display("FAIL mid strobe: ctl=%b wdata=%h want 1010000 a5", obs, uart_wdata);
        end
        rst = 1'b0; #1;
        n_checks++;
        if (obs !== 7'b0) begin n_fail++; $display("FAIL mid rst_ctl: ctl=%b want=%b", obs, 7'b0); end
        n_checks++;
        if ({uart_wdata, rdata1, rdata0} !== 24'h0) begin
            n_fail++; $display("FAIL mid rst_data: got %h want 000000", {uart_wdata, rdata1, rdata0});
        end
        last_m = 1'b1; rd_m[0] = 8'h00; rd_m[1] = 8'h00;
        @(negedge clk); n_checks++;
        if (obs !== 7'b0) begin n_fail++; $display("FAIL mid rst_hold: ctl=%b want=%b", obs, 7'b0); end
        @(posedge clk); #1;
        rst = 1'b1; uart_busy = 1'b1;
        do_txn("post_rst", 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 8'hB4, 1, 8'hE7);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_write_basic();
        test_busy_hold();
        test_random();
        test_timeout();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
